// File: rtl/status_register_unit_pkg.sv
// Shared core constants for the status register: flag bit positions and width.
// The condition checker imports this package too, so bit positions stay in one place.
package status_register_unit_pkg;

  localparam int SR_W   = 4;
  localparam int FLAG_Z = 3;
  localparam int FLAG_C = 2;
  localparam int FLAG_N = 1;
  localparam int FLAG_V = 0;

  typedef logic [SR_W-1:0] sr_vec_t;

  function automatic sr_vec_t pack_flags(input logic z, input logic c,
                                         input logic n, input logic v);
    sr_vec_t r;
    r         = '0;
    r[FLAG_Z] = z;
    r[FLAG_C] = c;
    r[FLAG_N] = n;
    r[FLAG_V] = v;
    return r;
  endfunction

endpackage

// File: rtl/status_register_unit_flag_gen.sv
// Combinational flag derivation from ALU/shifter results.
// Logical ops take carry from the shifter and keep the previous overflow flag.
module flag_gen
  import status_register_unit_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic [DATA_W-1:0] alu_res,
  input  logic              arith,
  input  logic              alu_c,
  input  logic              alu_v,
  input  logic              shift_c,
  input  logic              v_prev,
  output logic [SR_W-1:0]   flags
);

  logic flag_z;
  logic flag_c;
  logic flag_n;
  logic flag_v;

  always_comb begin
    flag_n = alu_res[DATA_W-1];
    flag_z = (alu_res == '0);
    flag_c = arith ? alu_c : shift_c;
    flag_v = arith ? alu_v : v_prev;
    flags  = pack_flags(flag_z, flag_c, flag_n, flag_v);
  end

endmodule

// File: rtl/status_register_unit.sv
// Architectural status register {z,c,n,v}: stall > direct write > ALU update > hold.
// sr_fwd exposes next-edge value for back-to-back flag consumers.
module status_register_unit
  import status_register_unit_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              stall,
  input  logic              flush,
  input  logic              s_en,
  input  logic              cond_pass,
  input  logic              arith,
  input  logic [DATA_W-1:0] alu_res,
  input  logic              alu_c,
  input  logic              alu_v,
  input  logic              shift_c,
  input  logic              wr_en,
  input  logic [SR_W-1:0]   wr_data,
  output logic [SR_W-1:0]   sr,
  output logic [SR_W-1:0]   sr_fwd,
  output logic              sr_upd
);

  logic [SR_W-1:0] sr_q;
  logic [SR_W-1:0] sr_nxt;
  logic [SR_W-1:0] alu_flags;
  logic            sr_upd_q;
  logic            dir_wr;
  logic            alu_upd;
  logic            upd_nxt;

  flag_gen #(
    .DATA_W (DATA_W)
  ) u_flag_gen (
    .alu_res (alu_res),
    .arith   (arith),
    .alu_c   (alu_c),
    .alu_v   (alu_v),
    .shift_c (shift_c),
    .v_prev  (sr_q[FLAG_V]),
    .flags   (alu_flags)
  );

  // Flush squashes only the EX instruction; a direct write still lands.
  assign dir_wr  = wr_en & ~stall;
  assign alu_upd = s_en & cond_pass & ~flush & ~stall & ~wr_en;
  assign upd_nxt = dir_wr | alu_upd;

  always_comb begin
    sr_nxt = sr_q;
    if (dir_wr) begin
      sr_nxt = wr_data;
    end else if (alu_upd) begin
      sr_nxt = alu_flags;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sr_q     <= '0;
      sr_upd_q <= 1'b0;
    end else begin
      sr_q     <= sr_nxt;
      sr_upd_q <= upd_nxt;
    end
  end

  assign sr     = sr_q;
  assign sr_fwd = sr_nxt;
  assign sr_upd = sr_upd_q;

endmodule

// File: tb/tb_status_register_unit.sv
// Self-checking bench for status_register_unit: vector table with a scoreboard
// queue, plus a hand-written asynchronous reset sequence.
module tb_status_register_unit;

  logic        clk;
  logic        rst;
  logic        stall;
  logic        flush;
  logic        s_en;
  logic        cond_pass;
  logic        arith;
  logic [31:0] alu_res;
  logic        alu_c;
  logic        alu_v;
  logic        shift_c;
  logic        wr_en;
  logic [3:0]  wr_data;
  logic [3:0]  sr;
  logic [3:0]  sr_fwd;
  logic        sr_upd;

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic        stall;
    logic        flush;
    logic        s_en;
    logic        cond_pass;
    logic        arith;
    logic        wr_en;
    logic [3:0]  wr_data;
    logic [31:0] alu_res;
    logic        alu_c;
    logic        alu_v;
    logic        shift_c;
    logic [3:0]  exp_fwd;
    logic        exp_upd;
  } vec_t;

  typedef struct {
    logic [3:0] sr;
    logic       upd;
  } exp_t;

  vec_t vecs[15];
  exp_t sb_q[$];

  status_register_unit #(.DATA_W(32)) dut (
    .clk       (clk),
    .rst       (rst),
    .stall     (stall),
    .flush     (flush),
    .s_en      (s_en),
    .cond_pass (cond_pass),
    .arith     (arith),
    .alu_res   (alu_res),
    .alu_c     (alu_c),
    .alu_v     (alu_v),
    .shift_c   (shift_c),
    .wr_en     (wr_en),
    .wr_data   (wr_data),
    .sr        (sr),
    .sr_fwd    (sr_fwd),
    .sr_upd    (sr_upd)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string name, input logic [3:0] act, input logic [3:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %b expected %b", name, act, exp);
    end
  endtask

  task automatic drive(input vec_t v);
    stall     = v.stall;
    flush     = v.flush;
    s_en      = v.s_en;
    cond_pass = v.cond_pass;
    arith     = v.arith;
    wr_en     = v.wr_en;
    wr_data   = v.wr_data;
    alu_res   = v.alu_res;
    alu_c     = v.alu_c;
    alu_v     = v.alu_v;
    shift_c   = v.shift_c;
  endtask

  task automatic apply(input vec_t v, input int idx);
    exp_t e;
    @(negedge clk);
    drive(v);
    #1;
    check($sformatf("sr_fwd[%0d]", idx), sr_fwd, v.exp_fwd);
    e.sr  = v.exp_fwd;
    e.upd = v.exp_upd;
    sb_q.push_back(e);
    @(posedge clk);
    #1;
    if (sb_q.size() == 0) begin
      total++;
      bad++;
      $display("FAIL scoreboard[%0d]: got empty queue expected entry", idx);
    end else begin
      e = sb_q.pop_front();
      check($sformatf("sr[%0d]", idx), sr, e.sr);
      check($sformatf("sr_upd[%0d]", idx), {3'b000, sr_upd}, {3'b000, e.upd});
    end
  endtask

  vec_t idle;

  initial begin
    //            stl flu sen cp  ari wen wdata    alu_res        c    v    shc  fwd      upd
    idle     = '{1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,4'b0000,32'h0000_0000,1'b0,1'b0,1'b0,4'b0000,1'b0};
    vecs[0]  = '{1'b0,1'b0,1'b1,1'b1,1'b1,1'b0,4'b0000,32'h0000_0000,1'b1,1'b0,1'b0,4'b1100,1'b1};
    vecs[1]  = '{1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,4'b0000,32'h0000_0000,1'b0,1'b0,1'b0,4'b1100,1'b0};
    vecs[2]  = '{1'b0,1'b0,1'b0,1'b0,1'b0,1'b1,4'b0001,32'h0000_0000,1'b0,1'b0,1'b0,4'b0001,1'b1};
    vecs[3]  = '{1'b0,1'b0,1'b1,1'b1,1'b0,1'b0,4'b0000,32'h8000_0000,1'b1,1'b0,1'b0,4'b0011,1'b1};
    vecs[4]  = '{1'b0,1'b0,1'b0,1'b0,1'b0,1'b1,4'b1000,32'h0000_0000,1'b0,1'b0,1'b0,4'b1000,1'b1};
    vecs[5]  = '{1'b0,1'b0,1'b1,1'b0,1'b1,1'b0,4'b0000,32'h0000_0005,1'b1,1'b1,1'b0,4'b1000,1'b0};
    vecs[6]  = '{1'b0,1'b1,1'b1,1'b1,1'b1,1'b0,4'b0000,32'h0000_0005,1'b1,1'b1,1'b0,4'b1000,1'b0};
    vecs[7]  = '{1'b0,1'b1,1'b0,1'b0,1'b0,1'b1,4'b0100,32'h0000_0000,1'b0,1'b0,1'b0,4'b0100,1'b1};
    vecs[8]  = '{1'b0,1'b0,1'b1,1'b1,1'b1,1'b1,4'b0110,32'h0000_0000,1'b0,1'b0,1'b0,4'b0110,1'b1};
    vecs[9]  = '{1'b1,1'b0,1'b1,1'b1,1'b1,1'b1,4'b1111,32'h0000_0000,1'b0,1'b0,1'b0,4'b0110,1'b0};
    vecs[10] = '{1'b1,1'b0,1'b1,1'b1,1'b1,1'b0,4'b0000,32'h0000_0000,1'b1,1'b1,1'b0,4'b0110,1'b0};
    vecs[11] = '{1'b0,1'b0,1'b0,1'b0,1'b0,1'b1,4'b0110,32'h0000_0000,1'b0,1'b0,1'b0,4'b0110,1'b1};
    vecs[12] = '{1'b0,1'b0,1'b1,1'b1,1'b1,1'b0,4'b0000,32'hFFFF_FFFF,1'b0,1'b1,1'b0,4'b0011,1'b1};
    vecs[13] = '{1'b0,1'b0,1'b1,1'b1,1'b0,1'b0,4'b0000,32'h0000_0001,1'b0,1'b0,1'b1,4'b0101,1'b1};
    vecs[14] = '{1'b0,1'b0,1'b0,1'b1,1'b1,1'b0,4'b0000,32'h0000_0000,1'b1,1'b1,1'b0,4'b0101,1'b0};

    rst = 1'b0;
    drive(idle);
    #2;
    check("reset_sr", sr, 4'b0000);
    check("reset_upd", {3'b000, sr_upd}, 4'b0000);
    check("reset_fwd", sr_fwd, 4'b0000);
    @(negedge clk);
    rst = 1'b1;

    for (int i = 0; i < 15; i++) begin
      apply(vecs[i], i);
    end

    // Load 1111 then pull reset low between edges while sr_upd is still high.
    @(negedge clk);
    drive(idle);
    wr_en   = 1'b1;
    wr_data = 4'b1111;
    @(posedge clk);
    #1;
    check("preload_sr", sr, 4'b1111);
    check("preload_upd", {3'b000, sr_upd}, 4'b0001);
    drive(idle);
    s_en      = 1'b1;
    cond_pass = 1'b1;
    arith     = 1'b1;
    alu_res   = 32'h0000_0001;
    alu_c     = 1'b0;
    alu_v     = 1'b1;
    #2;
    rst = 1'b0;
    #1;
    check("async_rst_sr", sr, 4'b0000);
    check("async_rst_upd", {3'b000, sr_upd}, 4'b0000);
    check("rst_low_fwd", sr_fwd, 4'b0001);
    @(posedge clk);
    #1;
    check("rst_held_sr", sr, 4'b0000);
    check("rst_held_upd", {3'b000, sr_upd}, 4'b0000);
    @(negedge clk);
    rst = 1'b1;
    #1;
    check("post_rst_fwd", sr_fwd, 4'b0001);
    @(posedge clk);
    #1;
    check("post_rst_sr", sr, 4'b0001);
    check("post_rst_upd", {3'b000, sr_upd}, 4'b0001);
    @(negedge clk);
    drive(idle);
    @(posedge clk);
    #1;
    check("idle_after_sr", sr, 4'b0001);
    check("idle_after_upd", {3'b000, sr_upd}, 4'b0000);

    if (sb_q.size() != 0) begin
      total++;
      bad++;
      $display("FAIL scoreboard_drain: got %0d left expected 0", sb_q.size());
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/status_register_unit.md
STATUS_REGISTER_UNIT -- requirements
Module: status_register_unit

Interface
REQ-001 SHALL have parameter DATA_W, default 32, width of the ALU result used for N/Z derivation.
REQ-002 SHALL have port clk  input  1  single clock, all state on rising edge.
REQ-003 SHALL have port rst  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have port stall  input  1  hold all state this cycle.
REQ-005 SHALL have port flush  input  1  squash the EX-stage instruction this cycle.
REQ-006 SHALL have port s_en  input  1  EX instruction has S bit set (requests flag update).
REQ-007 SHALL have port cond_pass  input  1  EX instruction's condition evaluated true.
REQ-008 SHALL have port arith  input  1  1 = arithmetic op (C,V from ALU); 0 = logical op (C from shifter, V preserved).
REQ-009 SHALL have port alu_res  input  DATA_W  ALU result.
REQ-010 SHALL have port alu_c  input  1  ALU carry-out.
REQ-011 SHALL have port alu_v  input  1  ALU signed overflow.
REQ-012 SHALL have port shift_c  input  1  shifter carry-out.
REQ-013 SHALL have port wr_en  input  1  direct status write (restore/MSR-style).
REQ-014 SHALL have port wr_data  input  4  direct write value, packed {z,c,n,v}.
REQ-015 SHALL have port sr  output  4  architectural status register, packed {z,c,n,v} (bit3=z, bit2=c, bit1=n, bit0=v), consumed by the condition checker.
REQ-016 SHALL have port sr_fwd  output  4  combinational next value of sr (bypass for back-to-back flag use).
REQ-017 SHALL have port sr_upd  output  1  registered pulse: sr changed source last edge.

Function
REQ-018 Flag derivation SHALL be: n = alu_res[DATA_W-1]; z = (alu_res == 0); c = arith ? alu_c : shift_c; v = arith ? alu_v : sr.v.
REQ-019 ALU update SHALL be enabled iff s_en & cond_pass & ~flush & ~stall & ~wr_en.
REQ-020 Direct write SHALL be enabled iff wr_en & ~stall; flush SHALL NOT block it.
REQ-021 Priority SHALL be: stall (hold) > wr_en > ALU update > hold.
REQ-022 sr_fwd SHALL equal the value sr will take on the next edge (wr_data, derived flags, or sr).
REQ-023 sr SHALL load sr_fwd on every rising clk edge; latency from qualified update to sr visible = 1 cycle, to sr_fwd = 0 cycles.
REQ-024 sr_upd SHALL be 1 in the cycle after an enabled ALU update or direct write, else 0; it SHALL assert even if the new value equals the old.
REQ-025 A failed condition (cond_pass=0) with s_en=1 SHALL leave sr unchanged and sr_upd=0.
REQ-026 Stall SHALL hold sr and force sr_upd to 0 next cycle.
REQ-027 Simultaneous wr_en and qualified ALU update SHALL apply wr_data only.

Reset
REQ-028 On rst low, sr SHALL go to 4'b0000 and sr_upd to 0 immediately, independent of clk.
REQ-029 Reset asserted mid-update SHALL discard the pending update; first update after rst deassert takes effect on the first edge with qualifying inputs.
REQ-030 sr_fwd SHALL reflect reset sr (0000) plus current inputs while rst is low.

Structure
REQ-031 Flag bit positions (Z=3, C=2, N=1, V=0) and SR width SHALL be constants in the shared core package, used by this block and the condition checker.
REQ-032 Flag derivation (REQ-018) SHALL be one combinational sub-module, flag_gen; state, priority and pulse logic stay in status_register_unit.

Verification
REQ-033 Reset, then s_en=1, cond_pass=1, arith=1, alu_res=0, alu_c=1, alu_v=0 -> sr_fwd=4'b1100 same cycle, sr=4'b1100 and sr_upd=1 next cycle.
REQ-034 sr=4'b0001, logical op s_en=1, cond_pass=1, arith=0, alu_res=32'h8000_0000, shift_c=0 -> sr=4'b0011 (V preserved).
REQ-035 sr=4'b1000, s_en=1, cond_pass=0, alu_res=5 -> sr stays 4'b1000, sr_upd=0; repeat with cond_pass=1, flush=1 -> same.
REQ-036 wr_en=1, wr_data=4'b0110 with qualified ALU update producing 4'b1000 -> sr=4'b0110; with stall=1 same cycle -> sr unchanged, sr_upd=0.
REQ-037 sr=4'b1111, assert rst low between edges -> sr=4'b0000 before next edge; deassert, qualified update with alu_res=1, arith=1, c=0, v=1 -> sr=4'b0001.
